// File: rtl/comb_sweep_pkg.sv
// comb_sweep_pkg: shared state encoding and parameter defaults for the truth-table sweeper
package comb_sweep_pkg;
    localparam int N_DEF          = 3;
    localparam int SETTLE_CYC_DEF = 4;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/comb_sweep_if.sv
// comb_sweep_if: bundle between the sweeper and the block under sweep plus its control/result side
interface comb_sweep_if import comb_sweep_pkg::*; #(parameter int N = N_DEF);
    logic               start;
    logic [2**N-1:0]    expected;
    logic               f_in;
    logic [N-1:0]       x_out;
    logic               busy;
    logic               done;
    logic [2**N-1:0]    table_out;
    logic               table_valid;
    logic               mismatch;
    logic [2**N-1:0]    mismatch_mask;
    modport master (output start, expected, f_in,
                    input  x_out, busy, done, table_out, table_valid, mismatch, mismatch_mask);
    modport slave  (input  start, expected, f_in,
                    output x_out, busy, done, table_out, table_valid, mismatch, mismatch_mask);
endinterface

// File: rtl/comb_sweep_settle_timer.sv
// settle_timer: dwell counter with clear/enable; tc flags the last settle cycle
module settle_timer #(parameter int SETTLE_CYC = 4) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
    assign tc = cnt_q == 8'(SETTLE_CYC - 1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/comb_sweep.sv
// comb_sweep: steps x_out through every code, samples f_in after a settle dwell, compares to a latched reference
module comb_sweep import comb_sweep_pkg::*; #(
    parameter int N          = N_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input logic          clk,
    input logic          rst,
    comb_sweep_if.slave  bus
);
    localparam int W = 2**N;
    state_t         state_q, state_d;
    logic [N-1:0]   x_q, x_d;
    logic [W-1:0]   tab_q, tab_d, exp_q, exp_d, mask_q, mask_d;
    logic           valid_q, valid_d, done_q, done_d, mis_q;
    logic           clr, en, tc;

    settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .tc(tc)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        tab_d   = tab_q;
        exp_d   = exp_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        en      = 1'b0;
        unique case (state_q)
            IDLE: if (bus.start) begin
                state_d = SETTLE;
                x_d     = '0;
                tab_d   = '0;
                valid_d = 1'b0;
                exp_d   = bus.expected;
                clr     = 1'b1;
            end
            SETTLE: begin
                en      = 1'b1;
                state_d = tc ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                tab_d[x_q] = bus.f_in;
                clr        = 1'b1;
                state_d    = &x_q ? DONE : SETTLE;
                x_d        = &x_q ? x_q : x_q + 1'b1;
            end
            DONE: begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                mask_d  = tab_q ^ exp_q;
                x_d     = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            tab_q   <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            tab_q   <= tab_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            mis_q   <= |mask_d;
        end
    end

    assign bus.x_out         = x_q;
    assign bus.busy          = state_q == SETTLE || state_q == SAMPLE;
    assign bus.done          = done_q;
    assign bus.table_out     = tab_q;
    assign bus.table_valid   = valid_q;
    assign bus.mismatch      = mis_q;
    assign bus.mismatch_mask = mask_q;
endmodule

// File: tb/tb_comb_sweep.sv
// tb_comb_sweep: scoreboard bench; stimulus queues expected sweep results, monitors check them on done
module tb_comb_sweep;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] f_mode = 2'd0;

    typedef struct {int cyc; logic [7:0] tab; logic [7:0] mask;} exp_t;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    comb_sweep_if #(.N(3)) b0 ();
    comb_sweep_if #(.N(3)) b1 ();

    comb_sweep #(.N(3), .SETTLE_CYC(4)) dut  (.clk(clk), .rst(rst), .bus(b0));
    comb_sweep #(.N(3), .SETTLE_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always_comb b0.f_in = f_mode == 2'd0 ? ^b0.x_out : f_mode == 2'd1;
    always_comb b1.f_in = 1'b1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic mon(input string tag, input exp_t e, input logic [7:0] tab, input logic [7:0] mask,
                       input logic mis, input logic valid, input logic busy, input logic [2:0] x);
        chk({tag, " done cycle"}, 64'(cyc), 64'(e.cyc));
        chk({tag, " table_out"}, 64'(tab), 64'(e.tab));
        chk({tag, " mismatch_mask"}, 64'(mask), 64'(e.mask));
        chk({tag, " mismatch"}, 64'(mis), 64'(|e.mask));
        chk({tag, " table_valid"}, 64'(valid), 64'd1);
        chk({tag, " busy at done"}, 64'(busy), 64'd0);
        chk({tag, " x_out at done"}, 64'(x), 64'd0);
    endtask

    always @(negedge clk) if (b0.done) begin
        if (q0.size() == 0) chk("dut unexpected done", 64'd1, 64'd0);
        else mon("dut", q0.pop_front(), b0.table_out, b0.mismatch_mask, b0.mismatch, b0.table_valid, b0.busy, b0.x_out);
    end

    always @(negedge clk) if (b1.done) begin
        if (q1.size() == 0) chk("dut1 unexpected done", 64'd1, 64'd0);
        else mon("dut1", q1.pop_front(), b1.table_out, b1.mismatch_mask, b1.mismatch, b1.table_valid, b1.busy, b1.x_out);
    end

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) return;
        end
        chk("drain timeout", 64'(q0.size() + q1.size()), 64'd0);
        q0.delete();
        q1.delete();
    endtask

    task automatic wait_x(input logic [2:0] v);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b0.x_out == v) return;
        end
        chk("wait x_out timeout", 64'(b0.x_out), 64'(v));
    endtask

    task automatic go(input logic [1:0] mode, input logic [7:0] ref_tab, input logic [7:0] tab,
                      input logic [7:0] mask, input bit push);
        exp_t e;
        f_mode      = mode;
        b0.expected = ref_tab;
        b0.start    = 1'b1;
        e.cyc = cyc + 1 + 41;
        e.tab = tab;
        e.mask = mask;
        if (push) q0.push_back(e);
        @(negedge clk);
        b0.start = 1'b0;
    endtask

    initial begin
        exp_t e;
        b0.start = 1'b0; b0.expected = '0;
        b1.start = 1'b0; b1.expected = '0;
        repeat (3) @(negedge clk);
        chk("reset x_out", 64'(b0.x_out), 64'd0);
        chk("reset busy", 64'(b0.busy), 64'd0);
        chk("reset done", 64'(b0.done), 64'd0);
        chk("reset table", 64'({b0.table_out, b0.mismatch_mask, b0.table_valid, b0.mismatch}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        go(2'd0, 8'h96, 8'h96, 8'h00, 1'b1);
        chk("busy in sweep", 64'(b0.busy), 64'd1);
        drain();
        go(2'd0, 8'h97, 8'h96, 8'h01, 1'b1);
        drain();
        go(2'd1, 8'h00, 8'hFF, 8'hFF, 1'b1);
        drain();
        go(2'd0, 8'h96, 8'h96, 8'h00, 1'b1);
        b0.expected = 8'h00;
        drain();
        // SETTLE_CYC=1 instance: each code held two cycles
        b1.expected = 8'hFF;
        b1.start    = 1'b1;
        e.cyc = cyc + 1 + 17; e.tab = 8'hFF; e.mask = 8'h00;
        q1.push_back(e);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            b1.start = 1'b0;
            chk($sformatf("dut1 x_out step %0d", j), 64'(b1.x_out), 64'(j / 2));
        end
        drain();
        go(2'd0, 8'h96, 8'h96, 8'h00, 1'b0);
        wait_x(3'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid reset x_out", 64'(b0.x_out), 64'd0);
        chk("mid reset busy", 64'(b0.busy), 64'd0);
        chk("mid reset outputs", 64'({b0.done, b0.table_out, b0.mismatch_mask, b0.table_valid, b0.mismatch}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        go(2'd0, 8'h96, 8'h96, 8'h00, 1'b1);
        drain();
        go(2'd0, 8'h96, 8'h96, 8'h00, 1'b1);
        wait_x(3'd5);
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        drain();
        // start held: back-to-back sweeps 42 cycles apart
        f_mode = 2'd0;
        b0.expected = 8'h96;
        b0.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e.cyc = cyc + 1 + 41 + 42 * k; e.tab = 8'h96; e.mask = 8'h00;
            q0.push_back(e);
        end
        repeat (100) @(negedge clk);
        b0.start = 1'b0;
        drain();
        repeat (60) @(negedge clk);
        chk("queues empty", 64'(q0.size() + q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
